// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: store-width codes,
// responder FSM states and lane helper functions.
package dmem_pkg;

    localparam logic [1:0] WIDTH_NONE = 2'd0;
    localparam logic [1:0] WIDTH_BYTE = 2'd1;
    localparam logic [1:0] WIDTH_HALF = 2'd2;
    localparam logic [1:0] WIDTH_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Bytes touched by an access; a read always fetches a full word.
    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 4'b0001;
            WIDTH_HALF: return 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    // True when the access spills into the next word.
    function automatic logic crosses(input logic [1:0] off, input logic [1:0] width);
        if (width == WIDTH_NONE) begin
            return off != 2'd0;
        end
        return ({1'b0, off} + width_bytes(width)) > 3'd4;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM built from four byte lanes, with per-lane write
// enables and a registered read port.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
                rdata_reg <= lane_mem[addr];
            end
        end

        assign rdata[8*gi +: 8] = rdata_reg;
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store-side data memory responder: byte-addressed accesses on a word RAM,
// with word-crossing accesses split over two RAM cycles.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_write_data,
    input  logic [1:0]        mem_write_width,
    output logic              rsp_valid,
    output logic              rsp_error,
    output logic [31:0]       mem_read_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-2:0] LAST_W = (ADDR_W-1)'(DEPTH_WORDS - 1);

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       lo_word_reg;
    logic [1:0]        width_reg;
    logic              err_reg;
    logic              cross_reg;
    logic              hi_oob_reg;

    logic [ADDR_W-1:0] src_addr;
    logic [31:0]       src_wdata;
    logic [1:0]        src_width;
    logic [ADDR_W-2:0] w_ext;
    logic [1:0]        off;
    logic              in_range;
    logic              last_word;
    logic              is_write;
    logic              crossing;
    logic [7:0]        lane_mask8;
    logic [63:0]       lane_data64;

    logic              bank_en;
    logic [3:0]        bank_we;
    logic [AW-1:0]     bank_addr;
    logic [31:0]       bank_wdata;
    logic [31:0]       bank_rdata;
    logic [63:0]       rd_pair;
    logic [63:0]       rd_shift;

    // IDLE drives the RAM straight from the request so access 0 lands on the accept edge.
    assign src_addr  = (state_reg == IDLE) ? mem_addr        : addr_reg;
    assign src_wdata = (state_reg == IDLE) ? mem_write_data  : wdata_reg;
    assign src_width = (state_reg == IDLE) ? mem_write_width : width_reg;

    assign off         = src_addr[1:0];
    assign w_ext       = {1'b0, src_addr[ADDR_W-1:2]};
    assign in_range    = w_ext <= LAST_W;
    assign last_word   = w_ext == LAST_W;
    assign is_write    = src_width != WIDTH_NONE;
    assign crossing    = crosses(off, src_width);
    assign lane_mask8  = {4'b0000, lane_mask(src_width)} << off;
    assign lane_data64 = {32'h0, src_wdata} << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = (in_range && crossing) ? SECOND : RESP;
                end
            end
            SECOND:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg    <= 1'b0;
            cross_reg  <= 1'b0;
            hi_oob_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                addr_reg   <= mem_addr;
                wdata_reg  <= mem_write_data;
                width_reg  <= mem_write_width;
                err_reg    <= !in_range;
                cross_reg  <= in_range && crossing;
                hi_oob_reg <= last_word;
            end
            if (state_reg == SECOND) begin
                lo_word_reg <= bank_rdata;
            end
        end
    end

    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_error     = 1'b0;
        mem_read_data = '0;
        bank_en       = 1'b0;
        bank_we       = '0;
        bank_addr     = w_ext[AW-1:0];
        bank_wdata    = lane_data64[31:0];
        rd_pair       = '0;
        rd_shift      = '0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                bank_en   = req_valid && in_range && !rst;
                bank_we   = is_write ? lane_mask8[3:0] : 4'b0000;
            end
            SECOND: begin
                // A reset here abandons the high word; the low word is already committed.
                bank_en    = !hi_oob_reg && !rst;
                bank_addr  = w_ext[AW-1:0] + AW'(1);
                bank_we    = is_write ? lane_mask8[7:4] : 4'b0000;
                bank_wdata = lane_data64[63:32];
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_error = err_reg;
                if (!err_reg && !is_write) begin
                    rd_pair = cross_reg ? {(hi_oob_reg ? 32'h0 : bank_rdata), lo_word_reg}
                                        : {32'h0, bank_rdata};
                    rd_shift      = rd_pair >> {addr_reg[1:0], 3'b000};
                    mem_read_data = rd_shift[31:0];
                end
            end
            default: ;
        endcase
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk  (clk),
        .en   (bank_en),
        .we   (bank_we),
        .addr (bank_addr),
        .wdata(bank_wdata),
        .rdata(bank_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset-in-SECOND
// sequence and randomized traffic against a byte-level memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH  = 64;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic [1:0]  mem_write_width = '0;
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] mem_read_data;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    logic [7:0] ref_mem [NBYTES];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_W     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write_width(mem_write_width),
        .rsp_valid      (rsp_valid),
        .rsp_error      (rsp_error),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] wd);
        return (wd == 2'd1) ? 1 : (wd == 2'd2) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [31:0] a);
        return 64'(a) >= 64'(NBYTES);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            longint b = longint'(64'(a)) + i;
            if (b < NBYTES) r[8*i +: 8] = ref_mem[int'(b)];
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] wd);
        for (int i = 0; i < nbytes_of(wd); i++) begin
            longint b = longint'(64'(a)) + i;
            if (b < NBYTES) ref_mem[int'(b)] = d[8*i +: 8];
        end
    endtask

    function automatic int model_lat(input logic [31:0] a, input logic [1:0] wd);
        int off = int'(a % 4);
        if (model_err(a)) return 1;
        if (wd == 2'd0) return (off != 0) ? 2 : 1;
        return (off + nbytes_of(wd) > 4) ? 2 : 1;
    endfunction

    // Called at a negedge with req_ready high; returns at the negedge after the response.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] wd,
                          input bit hold, output int lat, output logic err,
                          output logic [31:0] rd, output logic busy_ready, output logic post_ok);
        lat = 0; err = 1'b0; rd = '0; busy_ready = 1'b0;
        mem_addr = a; mem_write_data = d; mem_write_width = wd; req_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (req_ready) busy_ready = 1'b1;
            if (rsp_valid) begin
                lat = k; err = rsp_error; rd = mem_read_data;
                req_valid = 1'b0;
                break;
            end
            if (hold) begin
                mem_addr = $urandom; mem_write_data = $urandom;
                mem_write_width = 2'($urandom_range(0, 3));
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        post_ok = req_ready && !rsp_valid;
    endtask

    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] wd, input bit hold, input int exp_lat,
                           input logic exp_err, input logic [31:0] exp_rd);
        int lat; logic err; logic [31:0] rd; logic busy_ready; logic post_ok;
        do_req(a, d, wd, hold, lat, err, rd, busy_ready, post_ok);
        txn_no++;
        $display("txn %0d %s addr=0x%08h wd=%0d data=0x%08h hold=%0b lat=%0d err=%0b rdata=0x%08h",
                 txn_no, tag, a, wd, d, hold, lat, err, rd);
        check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_err", tag), {31'b0, err}, {31'b0, exp_err});
        check($sformatf("%s_rdata", tag), rd, exp_rd);
        check($sformatf("%s_busy_ready", tag), {31'b0, busy_ready}, 32'h0);
        check($sformatf("%s_post_ready", tag), {31'b0, post_ok}, 32'h1);
        if (!model_err(a) && wd != 2'd0) model_write(a, d, wd);
    endtask

    task automatic run_model(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] wd, input bit hold);
        logic [31:0] exp_rd;
        exp_rd = (model_err(a) || wd != 2'd0) ? 32'h0 : model_read(a);
        run_txn(tag, a, d, wd, hold, model_lat(a, wd), model_err(a), exp_rd);
    endtask

    function automatic void add(input logic [31:0] a, input logic [31:0] d, input logic [1:0] wd,
                                input int lat, input logic err, input logic [31:0] rd);
        vec_t v;
        v.addr = a; v.wdata = d; v.width = wd; v.lat = lat; v.err = err; v.rdata = rd;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'h1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_rsp_error", {31'b0, rsp_error}, 32'h0);
        check("reset_read_data", mem_read_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) begin
            run_model("init", 32'(4 * i), $urandom, 2'd3, 1'b0);
        end

        add(32'h10, 32'hDEADBEEF, 2'd3, 1, 1'b0, 32'h0);
        add(32'h10, 32'h0,        2'd0, 1, 1'b0, 32'hDEADBEEF);
        add(32'h14, 32'h0,        2'd3, 1, 1'b0, 32'h0);
        add(32'h12, 32'h5A,       2'd1, 1, 1'b0, 32'h0);
        add(32'h12, 32'h0,        2'd0, 2, 1'b0, 32'h0000DE5A);
        add(32'h10, 32'h0,        2'd0, 1, 1'b0, 32'hDE5ABEEF);
        add(32'h10, 32'h0,        2'd3, 1, 1'b0, 32'h0);
        add(32'h13, 32'hA1B2,     2'd2, 2, 1'b0, 32'h0);
        add(32'h10, 32'h0,        2'd0, 1, 1'b0, 32'hB2000000);
        add(32'h14, 32'h0,        2'd0, 1, 1'b0, 32'h000000A1);
        add(32'h13, 32'h0,        2'd0, 2, 1'b0, 32'h0000A1B2);
        add(32'h11, 32'h0,        2'd0, 2, 1'b0, 32'hA1B20000);
        add(32'h16, 32'hBEEF,     2'd2, 1, 1'b0, 32'h0);
        add(32'h14, 32'h0,        2'd0, 1, 1'b0, 32'hBEEF00A1);
        add(32'(NBYTES), 32'h0,   2'd0, 1, 1'b1, 32'h0);
        add(32'(NBYTES), 32'h12345678, 2'd3, 1, 1'b1, 32'h0);
        add(32'(NBYTES - 4), 32'hCAFEF00D, 2'd3, 1, 1'b0, 32'h0);
        add(32'(NBYTES - 2), 32'h0, 2'd0, 2, 1'b0, 32'h0000CAFE);
        add(32'(NBYTES - 1), 32'h1234, 2'd2, 2, 1'b0, 32'h0);
        add(32'(NBYTES - 4), 32'h0, 2'd0, 1, 1'b0, 32'h34FEF00D);
        add(32'hFFFFFFFC, 32'h0,  2'd0, 1, 1'b1, 32'h0);
        add(32'h1C, 32'h0,        2'd3, 1, 1'b0, 32'h0);
        add(32'h20, 32'h55667788, 2'd3, 1, 1'b0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].width,
                    bit'(i % 2), vecs[i].lat, vecs[i].err, vecs[i].rdata);
        end

        // Crossing store interrupted by reset while the high word is pending.
        mem_addr = 32'h1E; mem_write_data = 32'h11223344; mem_write_width = 2'd3; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        check("rst2_rsp_in_second", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rst2_rsp_after_reset", {31'b0, rsp_valid}, 32'h0);
        check("rst2_ready_after_reset", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        check("rst2_rsp_later", {31'b0, rsp_valid}, 32'h0);
        $display("txn %0d rst_second addr=0x0000001e wd=3 data=0x11223344 aborted", ++txn_no);
        ref_mem[32'h1E] = 8'h44;
        ref_mem[32'h1F] = 8'h33;
        run_txn("rst2_low", 32'h1C, 32'h0, 2'd0, 1'b0, 1, 1'b0, 32'h33440000);
        run_txn("rst2_high", 32'h20, 32'h0, 2'd0, 1'b0, 1, 1'b0, 32'h55667788);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int sel = $urandom_range(0, 9);
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = 32'(NBYTES - $urandom_range(1, 8));
            else               a = 32'($urandom_range(0, NBYTES - 1));
            run_model("rand", a, $urandom, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the load/store side of the core: accepts the byte address, write data and write-width code that the load/store unit drives, performs the access on an internal word-organised RAM, and returns a 32-bit read word whose addressed byte sits in bits [7:0]. This lets the load/store unit sign- or zero-extend directly from the low bits. Unaligned accesses that cross a word boundary are split into two RAM cycles by a small state machine.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- mem_addr  in  ADDR_W  byte address.
- mem_write_data  in  32  store data, right-justified (bits [7:0] = first byte).
- mem_write_width  in  2  0 = read; 1 = byte; 2 = half; 3 = word store.
- rsp_valid  out  1  one-cycle pulse, completion of accepted request.
- rsp_error  out  1  qualified by rsp_valid; address out of range.
- mem_read_data  out  32  qualified by rsp_valid on reads; 0 for writes and errors.

## Operation
- Accept occurs when req_valid && req_ready. mem_addr, mem_write_data and mem_write_width are registered at accept; later input changes are ignored.
- off = addr[1:0]; w = addr[ADDR_W-1:2]; nbytes = 1/2/4 for width 1/2/3. A read always fetches 4 bytes.
- Crossing: read when off != 0; write when off + nbytes > 4.
- Range check: w >= DEPTH_WORDS gives an error. There is no RAM access; rsp_valid=1 with rsp_error=1, and mem_read_data=0.
- Second word w+1 >= DEPTH_WORDS (crossing only) is not an error. Write bytes to it are dropped, and read bytes from it return 0x00.
- Write lanes:
  - 64-bit data = write_data << 8*off.
  - 8-bit mask = ((1<<nbytes)-1) << off.
  - Low 4 mask/data bits go to word w; high 4 go to word w+1.
- Read assembly: mem_read_data = ({word(w+1), word(w)} >> 8*off)[31:0]. Aligned reads use word(w) only.
- States:
  - IDLE: accept. Error goes to RESP. Non-crossing does access 0 and goes to RESP. Crossing does access 0 and goes to SECOND.
  - SECOND: access word w+1 and go to RESP.
  - RESP: assert rsp_valid and go to IDLE.
- Memory contents are not cleared by rst.

## Timing
- RAM is single-port with synchronous read, 1-cycle latency, and per-byte write enables.
- Accept at cycle T:
  - Non-crossing or error: rsp_valid at T+1.
  - Crossing: rsp_valid at T+2.
- Non-crossing writes commit at the T edge. Crossing writes commit the low word at T and the high word at T+1.
- req_ready is low from T+1 until the cycle after rsp_valid. Maximum throughput is one request per 2 cycles, or one per 3 when crossing.
- Reset values: req_ready=1 (state IDLE), rsp_valid=0, rsp_error=0, mem_read_data=0.
- Reset mid-operation: a pending response is dropped. A crossing write interrupted in SECOND keeps its low-word bytes and never writes the high word.
- Read-after-write to the same bytes in back-to-back requests returns the new data.

## Structure
- Shared package dmem_pkg holds:
  - width codes WIDTH_NONE=0, WIDTH_BYTE=1, WIDTH_HALF=2, WIDTH_WORD=3 (shared with the load/store unit);
  - state enum {IDLE, SECOND, RESP}.
- Sub-module dmem_bank: DEPTH_WORDS x 32 single-port RAM with 4 byte enables and synchronous read.
- Lane shift, mask and assembly logic stay in the top module.

## Test plan
- Aligned word: sw 0xDEADBEEF to 0x10, then read 0x10 → rsp_valid at T+1 with 0xDEADBEEF, rsp_error=0.
- Byte store/read:
  - Setup: 0x10 holds 0xDEADBEEF.
  - Stimulus: sb 0x5A to 0x12, then read 0x12.
  - Required: rsp at T+2 (crossing read) with data[7:0]=0x5A and data[15:8]=0xDE; word 0x10 = 0xDE5ABEEF.
- Crossing half store:
  - Setup: words 0x10/0x14 = 0.
  - Stimulus: sh 0xA1B2 to 0x13.
  - Required: rsp at T+2; word 0x10 = 0xB2000000, word 0x14 = 0x000000A1; read 0x13 returns 0x0000A1B2.
- Out of range: read at 4*DEPTH_WORDS → rsp_valid at T+1 with rsp_error=1 and mem_read_data=0; RAM unchanged.
- Reset in SECOND:
  - Stimulus: crossing sw 0x11223344 to 0x1E, with rst high in cycle T+1.
  - Required: word 0x1C bytes [3:2] = 0x44/0x33 in little-endian order (= 0x3344xxxx); word 0x20 unchanged; no rsp_valid; req_ready=1 after reset.
- Handshake hold: req_valid held high with changing inputs while busy → only the accepted request executes, and req_ready returns high the cycle after rsp_valid.
